adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares the single 8-bit ripple adder (`full_adder`) between two requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester at a time, registers the operands and drives the shared adder. It returns the 8-bit sum to the granted requester under a second valid/ready handshake. The block sits between the ALU front-end requesters and the adder datapath.

## Interface
- `DATA_W`, 8: operand and result width. Only 8 is supported, to match the adder.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  2: bit i = requester i has an operand pair.
- `req_ready`  out  2: bit i = requester i's operands are accepted this cycle.
- `a0`, `b0`  in  8 each: requester 0 operands.
- `a1`, `b1`  in  8 each: requester 1 operands.
- `rsp_valid`  out  2: bit i = `rsp_sum` belongs to requester i.
- `rsp_ready`  in  2: bit i = requester i consumes the response.
- `rsp_sum`  out  8: registered sum, A+B mod 256.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, CALC and RESP.
- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise select the grant `g`, assert `req_ready[g]` combinationally and capture `a_g`/`b_g` into `op_a`/`op_b`.
  - Latch `g` and go to CALC.
  - Accept occurs when `req_valid[g] & req_ready[g]`, which always holds when the grant is issued.
- **CALC**: the adder sees `op_a`/`op_b`. Capture its output into `rsp_sum` and go to RESP.
- **RESP**
  - Hold `rsp_valid[g]=1` and `rsp_sum` stable.
  - When `rsp_ready[g]=1`, clear `rsp_valid` and go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in CALC and RESP. A new request is never accepted in the same cycle a response completes.
- Arithmetic: the carry out of bit 7 is discarded. 0xFF+0x01 gives 0x00 with no flag.
- Arbitration (see Configuration) uses the `last_grant` register, which is updated only on accept.
- Requesters must hold valid and operands stable until accepted. A valid dropped before accept is simply not served.
- Reset in any state:
  - State returns to IDLE, the in-flight transaction is discarded and no response is issued.
  - `op_a`, `op_b` and `rsp_sum` reset to 0x00.
  - `rsp_valid`, `req_ready` and `busy` reset to 0.
  - `last_grant` resets to 1, so requester 0 wins the first contention.

## Timing
- Accept in cycle T, CALC in T+1, `rsp_valid` high from T+2.
- Minimum spacing between accepts is 3 cycles, when `rsp_ready` is held high.
- With `rsp_ready` low, RESP holds indefinitely with no timeout.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. No other output is combinational from inputs.
- `busy` is registered, derived from state.

## Configuration
- `ADDER_ARB_RR_EN`
  - **Defined:** round-robin arbitration. On contention, the requester not equal to `last_grant` wins. A lone requester always wins.
  - **Undefined:** fixed priority, requester 0 always wins on contention. `last_grant` is still maintained but does not affect selection.

## Structure
- `adder_arb_pkg` holds:
  - the state typedef: IDLE=2'b00, CALC=2'b01, RESP=2'b10;
  - `NUM_REQ=2`;
  - `DATA_W=8`.
- `adder_arb_pick` is the sub-module: a combinational grant picker.
  - Inputs: `req_valid[1:0]` and `last_grant`.
  - Outputs: `gnt_vld` and `gnt_idx`.
  - The `ADDER_ARB_RR_EN` selection logic lives here.
- The top level instantiates `adder_arb_pick`, the FSM, the operand/result registers and one `full_adder` instance.

## Test plan
- **Reset mid-RESP**
  - Stimulus: accept 0x10+0x20 from req0, then drop `rst_n` for 1 cycle while in RESP.
  - Required: `rsp_valid`=0, `busy`=0 and `rsp_sum`=0x00 next cycle. No response appears afterwards.
- **Single request**
  - Stimulus: req0 sends 0x12+0x34 with `rsp_ready[0]`=1.
  - Required: `req_ready[0]` in T, `rsp_valid[0]`=1 and `rsp_sum`=0x46 in T+2, then IDLE at T+3.
- **Wrap-around**
  - Stimulus: req1 sends 0xFF+0x01, then 0x80+0x80.
  - Required: `rsp_sum`=0x00 both times, with `rsp_valid[1]` only.
- **Contention**
  - Stimulus: both requesters valid continuously after reset.
  - Required with RR: grants go 0,1,0,1.
  - Required without RR: grants go 0,0,0.
- **Backpressure**
  - Stimulus: hold `rsp_ready[0]`=0 for 5 cycles in RESP with req1 valid.
  - Required: `rsp_sum` stays stable and `req_ready`=0 throughout. Req1 is accepted the cycle after `rsp_ready[0]` rises.
- **Wrong-requester ready**
  - Stimulus: in RESP for g=0, assert `rsp_ready[1]` only.
  - Required: the block stays in RESP with `rsp_valid[0]` held.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester adder arbiter.
package adder_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/adder_arb_pick.sv
// Combinational grant picker for the adder arbiter.
// Build option: ADDER_ARB_RR_EN selects round-robin on contention; when it is
// undefined requester 0 has fixed priority and last_grant is ignored.
module adder_arb_pick
  import adder_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               last_grant,
  output logic               gnt_vld,
  output logic               gnt_idx
);

  // Kept so the fixed-priority build does not leave the port dangling.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Pick the winner; a lone requester always wins regardless of history.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = 1'b0;
`ifdef ADDER_ARB_RR_EN
    if (&req_valid) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req_valid[1];
    end
`else
    gnt_idx = req_valid[1] & ~req_valid[0];
`endif
  end

endmodule

// File: rtl/full_adder.sv
// Shared ripple-carry adder; carry out of the top bit is dropped, so the
// result is A+B modulo 2**W.
module full_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  // Bit-serial carry chain; the carry generated by the top bit is never formed.
  for (genvar i = 0; i < W - 1; i++) begin : g_carry
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  // Sum bits from the propagated carries.
  assign sum = a ^ b ^ carry;

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one shared 8-bit adder.
// Build option: ADDER_ARB_RR_EN (round-robin on contention, else requester 0
// has fixed priority); the choice lives in adder_arb_pick.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; grant and operand capture happen here
// CALC  | adder sees op_a/op_b; sum captured at the end of the cycle
// RESP  | rsp_valid[grant] held with stable rsp_sum until consumed
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
  logic [DATA_W-1:0] add_sum;
  logic              busy_q;
  logic              gnt_vld, gnt_idx;

  adder_arb_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  full_adder #(.W(DATA_W)) u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (add_sum)
  );

  // Next-state, operand capture and the combinational accept strobe.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_sum_d    = rsp_sum_q;
    req_ready    = 2'b00;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          // Masked by reset so nothing looks accepted while rst_n is low.
          req_ready[gnt_idx] = rst_n;
          grant_d            = gnt_idx;
          last_grant_d       = gnt_idx;
          op_a_d             = gnt_idx ? a1 : a0;
          op_b_d             = gnt_idx ? b1 : b0;
          state_d            = CALC;
        end
      end
      CALC: begin
        rsp_sum_d = add_sum;
        state_d   = RESP;
      end
      RESP: begin
        // Only the granted requester's ready can retire the response.
        if (rsp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_sum_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_sum_q    <= rsp_sum_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // Response valid is a pure decode of registered state and grant.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == RESP) begin
      rsp_valid[grant_q] = 1'b1;
    end
  end

  assign rsp_sum = rsp_sum_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter.
module tb_adder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_sum;
  logic       busy;

  int n_chk;
  int n_fail;

  adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held for the requester.
  task automatic txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_sum);
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    if (idx == 1) begin a1 = a; b1 = b; end
    else begin a0 = a; b0 = b; end
    req_valid = oh;
    rsp_ready = oh;
    #1;
    check("txn_req_ready_T", {14'd0, req_ready}, {14'd0, oh});
    check("txn_busy_T", {15'd0, busy}, 16'd0);
    next();
    req_valid = 2'b00;
    #1;
    check("txn_busy_T1", {15'd0, busy}, 16'd1);
    check("txn_rsp_valid_T1", {14'd0, rsp_valid}, 16'd0);
    check("txn_req_ready_T1", {14'd0, req_ready}, 16'd0);
    next();
    check("txn_rsp_valid_T2", {14'd0, rsp_valid}, {14'd0, oh});
    check("txn_rsp_sum_T2", {8'd0, rsp_sum}, {8'd0, exp_sum});
    next();
    check("txn_busy_T3", {15'd0, busy}, 16'd0);
    check("txn_rsp_valid_T3", {14'd0, rsp_valid}, 16'd0);
  endtask

  initial begin
    int grants[$];
    int exp_g[4];
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    next();
    next();
    check("rst_req_ready", {14'd0, req_ready}, 16'd0);
    check("rst_rsp_valid", {14'd0, rsp_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rsp_sum", {8'd0, rsp_sum}, 16'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    next();

    // Single request and wrap-around cases.
    txn(0, 8'h12, 8'h34, 8'h46);
    txn(1, 8'hFF, 8'h01, 8'h00);
    txn(1, 8'h80, 8'h80, 8'h00);

    // Backpressure plus wrong-requester ready, req1 waiting behind.
    a0 = 8'h55; b0 = 8'h0A; a1 = 8'h03; b1 = 8'h04;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    check("bp_req_ready_T", {14'd0, req_ready}, 16'h1);
    next();
    req_valid = 2'b10;
    next();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i < 2) ? 2'b10 : 2'b00;
      #1;
      check("bp_rsp_valid", {14'd0, rsp_valid}, 16'h1);
      check("bp_rsp_sum", {8'd0, rsp_sum}, 16'h5F);
      check("bp_req_ready", {14'd0, req_ready}, 16'h0);
      check("bp_busy", {15'd0, busy}, 16'd1);
      next();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_no_accept_on_retire", {14'd0, req_ready}, 16'h0);
    next();
    rsp_ready = 2'b10;
    #1;
    check("bp_req1_accept", {14'd0, req_ready}, 16'h2);
    next();
    req_valid = 2'b00;
    next();
    check("bp_req1_rsp_valid", {14'd0, rsp_valid}, 16'h2);
    check("bp_req1_rsp_sum", {8'd0, rsp_sum}, 16'h07);
    next();

    // Reset while a response is pending.
    a0 = 8'h10; b0 = 8'h20;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    next();
    req_valid = 2'b00;
    next();
    check("mid_rsp_valid", {14'd0, rsp_valid}, 16'h1);
    check("mid_rsp_sum", {8'd0, rsp_sum}, 16'h30);
    rst_n = 1'b0;
    next();
    check("mid_rst_rsp_valid", {14'd0, rsp_valid}, 16'h0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_rsp_sum", {8'd0, rsp_sum}, 16'h0);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      next();
      check("mid_no_late_rsp", {14'd0, rsp_valid}, 16'h0);
    end

    // Contention: both valid continuously, last_grant fresh from reset.
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready == 2'b01) grants.push_back(0);
      else if (req_ready == 2'b10) grants.push_back(1);
      if (rsp_valid == 2'b01) check("cont_sum_g0", {8'd0, rsp_sum}, 16'h02);
      if (rsp_valid == 2'b10) check("cont_sum_g1", {8'd0, rsp_sum}, 16'h04);
      next();
    end
    req_valid = 2'b00;
`ifdef ADDER_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check("cont_grant_count", grants.size(), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check($sformatf("cont_grant_%0d", i), grants[i], exp_g[i]);
      else check($sformatf("cont_grant_%0d_missing", i), 16'hFFFF, exp_g[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
